// File: rtl/mips_exec_unit_if.sv
// Bus between CPU control and the MIPS execution slice.
// master: control side (drives operands), slave: exec unit.
interface mips_exec_unit_if;
    logic        hl_write_en;
    logic [31:0] instr_word;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] mem_readdata;
    logic [31:0] result;
    logic [31:0] eff_addr;
    logic        b_flag;
    logic [31:0] load_data;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    modport master (
        output hl_write_en, instr_word, op1, op2, mem_readdata,
        input  result, eff_addr, b_flag, load_data, hi_out, lo_out
    );

    modport slave (
        input  hl_write_en, instr_word, op1, op2, mem_readdata,
        output result, eff_addr, b_flag, load_data, hi_out, lo_out
    );
endinterface

// File: rtl/mips_exec_unit.sv
// MIPS execution slice: ALU, branch test, effective address,
// load formatter and the HI/LO register pair.
// Ports: clk, reset (async, active-low), bus (slave modport):
//   in  hl_write_en, instr_word, op1, op2, mem_readdata
//   out result, eff_addr, b_flag, load_data, hi_out, lo_out
// Define EXEC_DIV_EN to build the DIV/DIVU divider; without it
// DIV/DIVU leave HI/LO unchanged.
module mips_exec_unit (
    input  logic              clk,
    input  logic              reset,
    mips_exec_unit_if.slave   bus
);
    logic [5:0]  opcode, funct;
    logic [4:0]  shamt, rt;
    logic [15:0] imm;
    logic [31:0] op1, op2, md;
    logic [31:0] simm, zimm;
    logic [31:0] hi, lo, hi_nxt, lo_nxt;
    logic [63:0] prod_s, prod_u;
    logic [1:0]  k;
    logic [4:0]  lwl_sh, lwr_sh;
    logic [31:0] byte_w;
    logic [15:0] half;

    assign opcode = bus.instr_word[31:26];
    assign rt     = bus.instr_word[20:16];
    assign imm    = bus.instr_word[15:0];
    assign shamt  = bus.instr_word[10:6];
    assign funct  = bus.instr_word[5:0];
    assign op1    = bus.op1;
    assign op2    = bus.op2;
    assign md     = bus.mem_readdata;
    assign simm   = {{16{imm[15]}}, imm};
    assign zimm   = {16'h0, imm};

    assign bus.eff_addr = op1 + simm;

    // ALU
    always_comb begin
        bus.result = 32'h0;
        case (opcode)
            6'd0: begin
                case (funct)
                    6'd0:  bus.result = op2 << shamt;
                    6'd2:  bus.result = op2 >> shamt;
                    6'd3:  bus.result = $signed(op2) >>> shamt;
                    6'd4:  bus.result = op2 << op1[4:0];
                    6'd6:  bus.result = op2 >> op1[4:0];
                    6'd7:  bus.result = $signed(op2) >>> op1[4:0];
                    6'd32,
                    6'd33: bus.result = op1 + op2;
                    6'd34,
                    6'd35: bus.result = op1 - op2;
                    6'd36: bus.result = op1 & op2;
                    6'd37: bus.result = op1 | op2;
                    6'd38: bus.result = op1 ^ op2;
                    6'd39: bus.result = ~(op1 | op2);
                    6'd42: bus.result =
                        {31'h0, $signed(op1) < $signed(op2)};
                    6'd43: bus.result = {31'h0, op1 < op2};
                    default: bus.result = 32'h0;
                endcase
            end
            6'd8,
            6'd9:  bus.result = op1 + simm;
            6'd10: bus.result =
                {31'h0, $signed(op1) < $signed(simm)};
            6'd11: bus.result = {31'h0, op1 < simm};
            6'd12: bus.result = op1 & zimm;
            6'd13: bus.result = op1 | zimm;
            6'd14: bus.result = op1 ^ zimm;
            6'd15: bus.result = {imm, 16'h0};
            default: bus.result = 32'h0;
        endcase
    end

    // Branch condition
    always_comb begin
        bus.b_flag = 1'b0;
        case (opcode)
            6'd1: begin
                if (rt == 5'd0 || rt == 5'd16)
                    bus.b_flag = op1[31];
                else if (rt == 5'd1 || rt == 5'd17)
                    bus.b_flag = ~op1[31];
            end
            6'd4: bus.b_flag = (op1 == op2);
            6'd5: bus.b_flag = (op1 != op2);
            6'd6: bus.b_flag = op1[31] | (op1 == 32'h0);
            6'd7: bus.b_flag = ~op1[31] & (op1 != 32'h0);
            default: bus.b_flag = 1'b0;
        endcase
    end

    // Load formatter; k selects the little-endian byte lane
    assign k      = bus.eff_addr[1:0];
    assign lwl_sh = {~k, 3'b000};
    assign lwr_sh = {k, 3'b000};
    assign byte_w = md >> lwr_sh;
    assign half   = bus.eff_addr[1] ? md[31:16] : md[15:0];

    always_comb begin
        bus.load_data = md;
        case (opcode)
            6'd32: bus.load_data = {{24{byte_w[7]}}, byte_w[7:0]};
            6'd36: bus.load_data = {24'h0, byte_w[7:0]};
            6'd33: bus.load_data = {{16{half[15]}}, half};
            6'd37: bus.load_data = {16'h0, half};
            6'd35: bus.load_data = md;
            6'd34: bus.load_data = (md << lwl_sh)
                | (op2 & ((32'h1 << lwl_sh) - 32'h1));
            6'd38: bus.load_data = (md >> lwr_sh)
                | (op2 & ~(32'hFFFF_FFFF >> lwr_sh));
            default: bus.load_data = md;
        endcase
    end

    // Multiplier
    assign prod_s = $signed({{32{op1[31]}}, op1})
                  * $signed({{32{op2[31]}}, op2});
    assign prod_u = {32'h0, op1} * {32'h0, op2};

`ifdef EXEC_DIV_EN
    // One unsigned divider serves both; DIV works on magnitudes
    // and fixes signs afterwards, so MIN/-1 wraps cleanly.
    logic        div_sgn;
    logic [31:0] dvd_mag, dvs_mag, dvs_safe;
    logic [31:0] q_mag, r_mag, quo, rem;

    assign div_sgn  = (funct == 6'd26);
    assign dvd_mag  = (div_sgn && op1[31]) ? -op1 : op1;
    assign dvs_mag  = (div_sgn && op2[31]) ? -op2 : op2;
    assign dvs_safe = (dvs_mag == 32'h0) ? 32'h1 : dvs_mag;
    assign q_mag    = dvd_mag / dvs_safe;
    assign r_mag    = dvd_mag % dvs_safe;
    assign quo = (div_sgn && (op1[31] ^ op2[31])) ? -q_mag : q_mag;
    assign rem = (div_sgn && op1[31]) ? -r_mag : r_mag;
`endif

    // HI/LO next state; non-writers leave both unchanged
    always_comb begin
        hi_nxt = hi;
        lo_nxt = lo;
        if (opcode == 6'd0) begin
            case (funct)
                6'd24: {hi_nxt, lo_nxt} = prod_s;
                6'd25: {hi_nxt, lo_nxt} = prod_u;
`ifdef EXEC_DIV_EN
                6'd26,
                6'd27: begin
                    if (op2 != 32'h0) begin
                        hi_nxt = rem;
                        lo_nxt = quo;
                    end
                end
`endif
                6'd17: hi_nxt = op1;
                6'd19: lo_nxt = op1;
                default: begin
                    hi_nxt = hi;
                    lo_nxt = lo;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi <= 32'h0;
            lo <= 32'h0;
        end else if (bus.hl_write_en) begin
            hi <= hi_nxt;
            lo <= lo_nxt;
        end
    end

    assign bus.hi_out = hi;
    assign bus.lo_out = lo;
endmodule

// File: tb/tb_mips_exec_unit.sv
// Scoreboard bench for mips_exec_unit: directed vectors push
// expected values; a monitor pops and compares on each sample.
module tb_mips_exec_unit;
    logic clk;
    logic reset;

    mips_exec_unit_if bus ();

    mips_exec_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sbq[$];
    event ev_s;
    int   checks = 0;
    int   errors = 0;

    localparam int S_RES = 0;
    localparam int S_EA  = 1;
    localparam int S_BF  = 2;
    localparam int S_LD  = 3;
    localparam int S_HI  = 4;
    localparam int S_LO  = 5;

    // Monitor
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(ev_s);
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                case (e.sel)
                    S_RES:   act = bus.result;
                    S_EA:    act = bus.eff_addr;
                    S_BF:    act = {31'h0, bus.b_flag};
                    S_LD:    act = bus.load_data;
                    S_HI:    act = bus.hi_out;
                    default: act = bus.lo_out;
                endcase
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h",
                             e.name, act, e.exp);
                end
            end
        end
    end

    function automatic logic [31:0] rt_i(
        input logic [5:0] fn, input logic [4:0] sh);
        return {6'd0, 5'd0, 5'd0, 5'd0, sh, fn};
    endfunction

    function automatic logic [31:0] it_i(
        input logic [5:0] op, input logic [4:0] rt,
        input logic [15:0] imm);
        return {op, 5'd0, rt, imm};
    endfunction

    task automatic push(input string n, input int s,
                        input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.sel  = s;
        e.exp  = v;
        sbq.push_back(e);
    endtask

    task automatic sample();
        #2;
        ->ev_s;
        #1;
    endtask

    task automatic apply(input logic [31:0] i, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] m);
        @(negedge clk);
        bus.instr_word   = i;
        bus.op1          = a;
        bus.op2          = b;
        bus.mem_readdata = m;
    endtask

    logic [31:0] eh, el;

    // Drive a HI/LO candidate for one edge, then check both regs
    task automatic wr(input string n, input logic [31:0] i,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic en);
        apply(i, a, b, 32'h0);
        bus.hl_write_en = en;
        @(posedge clk);
        #1;
        bus.hl_write_en = 1'b0;
        push({n, "_hi"}, S_HI, eh);
        push({n, "_lo"}, S_LO, el);
        sample();
    endtask

    localparam logic [31:0] MD = 32'h8899_AABB;

    initial begin
        reset            = 1'b0;
        bus.hl_write_en  = 1'b0;
        bus.instr_word   = 32'h0;
        bus.op1          = 32'h0;
        bus.op2          = 32'h0;
        bus.mem_readdata = 32'h0;

        @(negedge clk);
        push("rst_hi", S_HI, 32'h0);
        push("rst_lo", S_LO, 32'h0);
        sample();
        reset = 1'b1;

        // ALU
        apply(it_i(6'd9, 5'd0, 16'h0001), 32'h7FFF_FFFF, 0, 0);
        push("addiu", S_RES, 32'h8000_0000);
        push("addiu_ea", S_EA, 32'h8000_0000);
        sample();
        apply(it_i(6'd10, 5'd0, 16'h0), 32'hFFFF_FFFF, 0, 0);
        push("slti", S_RES, 32'h1);
        sample();
        apply(it_i(6'd11, 5'd0, 16'h0), 32'hFFFF_FFFF, 0, 0);
        push("sltiu", S_RES, 32'h0);
        sample();
        apply(rt_i(6'd33, 5'd0), 32'd5, 32'd3, 0);
        push("addu", S_RES, 32'd8);
        sample();
        apply(rt_i(6'd35, 5'd0), 32'd3, 32'd5, 0);
        push("subu", S_RES, 32'hFFFF_FFFE);
        sample();
        apply(rt_i(6'd3, 5'd4), 0, 32'h8000_0000, 0);
        push("sra", S_RES, 32'hF800_0000);
        sample();
        apply(rt_i(6'd6, 5'd0), 32'd4, 32'h8000_0000, 0);
        push("srlv", S_RES, 32'h0800_0000);
        sample();
        apply(rt_i(6'd39, 5'd0), 0, 0, 0);
        push("nor", S_RES, 32'hFFFF_FFFF);
        sample();
        apply(rt_i(6'd42, 5'd0), 32'hFFFF_FFFF, 32'd1, 0);
        push("slt", S_RES, 32'h1);
        sample();
        apply(rt_i(6'd43, 5'd0), 32'hFFFF_FFFF, 32'd1, 0);
        push("sltu", S_RES, 32'h0);
        sample();
        apply(rt_i(6'd1, 5'd0), 32'd7, 32'd9, 0);
        push("bad_funct", S_RES, 32'h0);
        sample();
        apply(it_i(6'd15, 5'd0, 16'h1234), 0, 0, 0);
        push("lui", S_RES, 32'h1234_0000);
        sample();
        apply(it_i(6'd13, 5'd0, 16'h8001), 32'hFFFF_0000, 0, 0);
        push("ori", S_RES, 32'hFFFF_8001);
        sample();
        apply(it_i(6'd63, 5'd0, 16'h1), 32'd5, 32'd5, 0);
        push("bad_op", S_RES, 32'h0);
        sample();

        // Branches
        apply(it_i(6'd1, 5'd17, 16'h0010), 32'h0, 0, 0);
        push("bgezal", S_BF, 32'h1);
        push("bgezal_ea", S_EA, 32'h10);
        sample();
        apply(it_i(6'd7, 5'd0, 16'hFFFC), 32'h0, 0, 0);
        push("bgtz", S_BF, 32'h0);
        push("bgtz_ea", S_EA, 32'hFFFF_FFFC);
        sample();
        apply(it_i(6'd5, 5'd0, 16'h0004), 32'h55, 32'h55, 0);
        push("bne", S_BF, 32'h0);
        push("bne_ea", S_EA, 32'h59);
        sample();
        apply(it_i(6'd4, 5'd0, 16'h0), 32'h55, 32'h55, 0);
        push("beq", S_BF, 32'h1);
        sample();
        apply(it_i(6'd1, 5'd0, 16'h0), 32'h8000_0000, 0, 0);
        push("bltz", S_BF, 32'h1);
        sample();
        apply(it_i(6'd6, 5'd0, 16'h0), 32'h0, 0, 0);
        push("blez", S_BF, 32'h1);
        sample();

        // Loads
        apply(it_i(6'd32, 5'd0, 16'h0), 32'h103, 0, MD);
        push("lb", S_LD, 32'hFFFF_FF88);
        sample();
        apply(it_i(6'd36, 5'd0, 16'h0), 32'h100, 0, MD);
        push("lbu", S_LD, 32'h0000_00BB);
        sample();
        apply(it_i(6'd33, 5'd0, 16'h0), 32'h102, 0, MD);
        push("lh", S_LD, 32'hFFFF_8899);
        sample();
        apply(it_i(6'd37, 5'd0, 16'h0), 32'h102, 0, MD);
        push("lhu", S_LD, 32'h0000_8899);
        sample();
        apply(it_i(6'd34, 5'd0, 16'h0), 32'h101, 32'h1122_3344, MD);
        push("lwl", S_LD, 32'hAABB_3344);
        sample();
        apply(it_i(6'd38, 5'd0, 16'h0), 32'h101, 32'h1122_3344, MD);
        push("lwr", S_LD, 32'h1188_99AA);
        sample();
        apply(it_i(6'd35, 5'd0, 16'h0), 32'h103, 0, MD);
        push("lw", S_LD, MD);
        sample();
        apply(it_i(6'd9, 5'd0, 16'h0), 32'h103, 0, MD);
        push("ld_other", S_LD, MD);
        sample();

        // HI/LO
        eh = 32'hFFFF_FFFF; el = 32'hFFFF_FFFA;
        wr("mult", rt_i(6'd24, 0), 32'hFFFF_FFFE, 32'd3, 1'b1);
        eh = 32'h2;
        wr("multu", rt_i(6'd25, 0), 32'hFFFF_FFFE, 32'd3, 1'b1);
        wr("mthi_noen", rt_i(6'd17, 0), 32'hDEAD, 0, 1'b0);
        wr("addu_en", rt_i(6'd33, 0), 32'd1, 32'd1, 1'b1);
`ifdef EXEC_DIV_EN
        eh = 32'hFFFF_FFFF; el = 32'hFFFF_FFFD;
`endif
        wr("div", rt_i(6'd26, 0), 32'hFFFF_FFF9, 32'd2, 1'b1);
`ifdef EXEC_DIV_EN
        eh = 32'h1; el = 32'hFFFF_FFFD;
`endif
        wr("div_neg", rt_i(6'd26, 0), 32'd7, 32'hFFFF_FFFE, 1'b1);
`ifdef EXEC_DIV_EN
        eh = 32'h2; el = 32'd14;
`endif
        wr("divu", rt_i(6'd27, 0), 32'd100, 32'd7, 1'b1);
        wr("divu_z", rt_i(6'd27, 0), 32'd100, 32'd0, 1'b1);
        wr("div_z", rt_i(6'd26, 0), 32'd100, 32'd0, 1'b1);
        eh = 32'h1234_5678;
        wr("mthi", rt_i(6'd17, 0), 32'h1234_5678, 0, 1'b1);
        el = 32'hCAFE_F00D;
        wr("mtlo", rt_i(6'd19, 0), 32'hCAFE_F00D, 0, 1'b1);

        // Back-to-back MULT then MTLO
        apply(rt_i(6'd24, 0), 32'd2, 32'd3, 0);
        bus.hl_write_en = 1'b1;
        @(posedge clk);
        #1;
        push("b2b_mult_hi", S_HI, 32'h0);
        push("b2b_mult_lo", S_LO, 32'd6);
        sample();
        apply(rt_i(6'd19, 0), 32'd9, 0, 0);
        @(posedge clk);
        #1;
        bus.hl_write_en = 1'b0;
        push("b2b_mtlo_hi", S_HI, 32'h0);
        push("b2b_mtlo_lo", S_LO, 32'd9);
        sample();

        // Reset mid-cycle, then reset versus write
        eh = 32'hABCD_0000;
        el = 32'd9;
        wr("pre_rst", rt_i(6'd17, 0), 32'hABCD_0000, 0, 1'b1);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        push("arst_hi", S_HI, 32'h0);
        push("arst_lo", S_LO, 32'h0);
        ->ev_s;
        #1;
        bus.instr_word  = rt_i(6'd17, 0);
        bus.op1         = 32'h7777;
        bus.hl_write_en = 1'b1;
        @(posedge clk);
        #1;
        push("rst_prio_hi", S_HI, 32'h0);
        sample();
        @(negedge clk);
        reset = 1'b1;
        bus.hl_write_en = 1'b0;
        eh = 32'h55;
        el = 32'h0;
        wr("post_rst", rt_i(6'd17, 0), 32'h55, 0, 1'b1);

        for (int i = 0; i < 100 && sbq.size() != 0; i++)
            @(posedge clk);
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0",
                     sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_exec_unit.md
# mips_exec_unit

Execution datapath slice of the Harvard MIPS core: the combinational integer ALU, with branch-condition and effective-address generation, plus the load-data formatter and the architectural HI/LO register pair. The CPU control/FSM presents the decoded instruction word and the register operands. It receives the ALU result, the branch flag, the memory address, the formatted load data and the HI/LO contents. Only HI/LO are state; everything else is combinational.

## Interface
- No parameters.
- clk  in  1  core clock; HI/LO update on rising edge
- reset  in  1  asynchronous, active-low; clears HI and LO
- hl_write_en  in  1  commit strobe; HI/LO load at the next posedge only if this is high and the instruction is a HI/LO writer
- instr_word  in  32  current instruction
- op1  in  32  rs register value
- op2  in  32  rt register value
- mem_readdata  in  32  aligned word read from data memory
- result  out  32  ALU result for register writeback
- eff_addr  out  32  op1 + sign-extended instr_word[15:0]
- b_flag  out  1  branch taken
- load_data  out  32  formatted load value for writeback
- hi_out, lo_out  out  32  current HI/LO register contents

## Operation
- Decode: opcode = [31:26], funct = [5:0], shamt = [10:6], rt field = [20:16]. All arithmetic is modulo 2^32. The block never traps or flags overflow.
- R-type (opcode 0), by funct:
  - 0 SLL, 2 SRL, 3 SRA: shift op2 by shamt.
  - 4 SLLV, 6 SRLV, 7 SRAV: shift op2 by op1[4:0].
  - 32/33 ADD/ADDU: op1+op2.
  - 34/35 SUB/SUBU: op1−op2.
  - 36 AND, 37 OR, 38 XOR, 39 NOR.
  - 42 SLT: signed compare, result 1/0.
  - 43 SLTU: unsigned compare, result 1/0.
  - Any other funct: result = 0.
- I-type:
  - 8/9 ADDI/ADDIU: op1 + sign-extended imm.
  - 10 SLTI: signed compare against sign-extended imm.
  - 11 SLTIU: unsigned compare against sign-extended imm.
  - 12 ANDI, 13 ORI, 14 XORI: zero-extended imm.
  - 15 LUI: {imm,16'h0}.
  - Any other opcode: result = 0.
- b_flag:
  - 4 BEQ: op1==op2. 5 BNE: op1!=op2.
  - 6 BLEZ: signed op1<=0. 7 BGTZ: signed op1>0.
  - Opcode 1, rt=0/16 BLTZ/BLTZAL: op1<0. rt=1/17 BGEZ/BGEZAL: op1>=0.
  - Else 0.
- HI/LO next values:
  - MULT (24): {HI,LO} = signed 64-bit product.
  - MULTU (25): {HI,LO} = unsigned 64-bit product.
  - DIV (26): LO = quotient, HI = remainder, signed, truncate toward zero; remainder takes the dividend's sign.
  - DIVU (27): same, unsigned.
  - DIV/DIVU with op2=0: HI and LO unchanged.
  - MTHI (17): HI = op1, LO unchanged. MTLO (19): LO = op1, HI unchanged.
  - MFHI/MFLO never modify HI/LO; the caller selects hi_out/lo_out.
- Load formatting uses little-endian lanes: byte k is mem_readdata[8k+7:8k], with k = eff_addr[1:0].
  - 32 LB: sign-extend byte k. 36 LBU: zero-extend byte k.
  - 33 LH: sign-extend halfword eff_addr[1]. 37 LHU: zero-extend it.
  - 35 LW: whole word; low address bits ignored.
  - 34 LWL: (mem_readdata << 8·(3−k)) | (op2 & low-mask of 8·(3−k) bits).
  - 38 LWR: (mem_readdata >> 8k) | (op2 & high-mask of 8k bits).
  - Any other opcode: load_data = mem_readdata.

## Timing
- result, eff_addr, b_flag and load_data are purely combinational from the inputs and HI/LO, with zero-cycle latency.
- HI/LO register writes commit at the posedge where hl_write_en=1; new values are visible on hi_out/lo_out after that edge.
- With hl_write_en=0, or a non-writer instruction, HI/LO hold.
- Reset low: HI=LO=0 immediately, independent of clk. Reset takes priority over a simultaneous write. Writes resume on the first posedge after reset goes high.
- Back-to-back writers (for example MULT followed by MTLO) must each see the previous cycle's committed HI/LO.

## Configuration
- EXEC_DIV_EN defined: DIV/DIVU implemented as specified.
- EXEC_DIV_EN undefined: no divider is built, and DIV/DIVU leave HI/LO unchanged (treated like the divide-by-zero case). All other behaviour is identical.

## Test plan
- ADDIU: op1=0x7FFFFFFF, imm=0x0001 → result=0x80000000, no trap. SLTI: op1=0xFFFFFFFF, imm=0 → result=1. SLTIU: same operands → result=0.
- MULT: op1=0xFFFFFFFE, op2=3 with hl_write_en=1 → after the edge HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU on the same operands → HI=2, LO=0xFFFFFFFA.
- DIV: op1=−7, op2=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with op2=0 → HI/LO unchanged. With EXEC_DIV_EN undefined, DIV also leaves HI/LO unchanged.
- MTHI: op1=0x12345678 → HI updated, LO retained. Assert reset low mid-cycle → both registers read 0 before the next edge.
- Loads with mem_readdata=0x8899AABB:
  - LB, eff_addr[1:0]=3 → 0xFFFFFF88. LBU, eff_addr[1:0]=0 → 0x000000BB.
  - LH, eff_addr[1]=1 → 0xFFFF8899.
  - LWL, k=1, op2=0x11223344 → 0xAABB3344. LWR, k=1, op2=0x11223344 → 0x118899AA.
- Branches: BGEZAL with op1=0 → b_flag=1. BGTZ with op1=0 → b_flag=0. BNE with equal operands → b_flag=0. Each with an imm giving the expected eff_addr.
